// File: rtl/uart_boot_ctrl.sv
// uart_boot_ctrl
//   Boot/debug controller. Parses framed commands from the UART receiver,
//   streams program words into instruction memory, and holds or releases
//   the core reset.
//
//   Frame: A5 <cmd> ...
//     01 LOAD : addr_lo addr_hi cnt_lo cnt_hi, 4*cnt data bytes (LE words), csum
//     02 RUN  : release core reset
//     03 HALT : hold core reset
//   Every frame ends with a single response byte: 'K' (0x4B) ok, 'E' (0x45) error.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   rx_data, rx_valid     : received byte + one-cycle strobe
//   tx_data, tx_valid,
//   tx_ready              : response byte, held until accepted
//   mem_we, mem_addr,
//   mem_wdata, mem_ready  : imem write request, held until accepted
//   cpu_reset             : core reset (1 = held)
//   busy                  : controller is inside a frame or response
module uart_boot_ctrl #(
    parameter int ADDR_W         = 12,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              cpu_reset,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SYNC    = 8'hA5;
    localparam logic [7:0] C_LOAD  = 8'h01;
    localparam logic [7:0] C_RUN   = 8'h02;
    localparam logic [7:0] C_HALT  = 8'h03;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR0, ADDR1, LEN0, LEN1, DATA, WRITE, CSUM, RESP
    } state_t;

    state_t         state;
    logic [7:0]     addr_lo;
    logic [7:0]     cnt_lo;
    logic [7:0]     csum;
    logic [15:0]    cnt;        // words still to be written
    logic [1:0]     byte_idx;   // byte lane of the word being assembled
    logic [TW-1:0]  tmo_cnt;    // idle clocks since the last received byte

    logic           timed;
    logic           tmo_hit;
    logic [15:0]    addr_full;
    logic [15:0]    cnt_full;

    always_comb begin
        // WRITE is excluded: the host must wait for the memory, not the other way round
        timed     = state inside {CMD, ADDR0, ADDR1, LEN0, LEN1, DATA, CSUM};
        tmo_hit   = timed && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
        addr_full = {rx_data, addr_lo};
        cnt_full  = {rx_data, cnt_lo};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            cpu_reset <= 1'b1;
            addr_lo   <= 8'h00;
            cnt_lo    <= 8'h00;
            csum      <= 8'h00;
            cnt       <= 16'h0;
            byte_idx  <= 2'd0;
            tmo_cnt   <= '0;
        end else begin
            // Outside the timed states the counter sits at zero, so entry to
            // CMD always starts a fresh window.
            tmo_cnt <= (timed && !rx_valid) ? tmo_cnt + TW'(1) : '0;

            if (tmo_hit) begin
                state    <= RESP;
                tx_data  <= RSP_ERR;
                tx_valid <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (rx_valid && rx_data == SYNC) state <= CMD;

                    CMD: if (rx_valid) begin
                        case (rx_data)
                            C_LOAD: begin
                                cpu_reset <= 1'b1;
                                csum      <= 8'h00;
                                byte_idx  <= 2'd0;
                                state     <= ADDR0;
                            end
                            C_RUN, C_HALT: begin
                                cpu_reset <= (rx_data == C_HALT);
                                tx_data   <= RSP_OK;
                                tx_valid  <= 1'b1;
                                state     <= RESP;
                            end
                            default: begin
                                tx_data  <= RSP_ERR;
                                tx_valid <= 1'b1;
                                state    <= RESP;
                            end
                        endcase
                    end

                    ADDR0: if (rx_valid) begin
                        addr_lo <= rx_data;
                        state   <= ADDR1;
                    end

                    ADDR1: if (rx_valid) begin
                        mem_addr <= addr_full[ADDR_W-1:0];
                        state    <= LEN0;
                    end

                    LEN0: if (rx_valid) begin
                        cnt_lo <= rx_data;
                        state  <= LEN1;
                    end

                    LEN1: if (rx_valid) begin
                        cnt   <= cnt_full;
                        state <= (cnt_full == 16'h0) ? CSUM : DATA;
                    end

                    DATA: if (rx_valid) begin
                        mem_wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            mem_we <= 1'b1;
                            state  <= WRITE;
                        end
                    end

                    WRITE: begin
                        if (rx_valid) begin
                            // Host overran the memory; a write accepted this same
                            // cycle has landed, but the frame is dead anyway.
                            mem_we   <= 1'b0;
                            tx_data  <= RSP_ERR;
                            tx_valid <= 1'b1;
                            state    <= RESP;
                        end else if (mem_ready) begin
                            mem_we   <= 1'b0;
                            mem_addr <= mem_addr + ADDR_W'(1);
                            cnt      <= cnt - 16'd1;
                            state    <= (cnt == 16'd1) ? CSUM : DATA;
                        end
                    end

                    CSUM: if (rx_valid) begin
                        tx_data  <= (rx_data == csum) ? RSP_OK : RSP_ERR;
                        tx_valid <= 1'b1;
                        state    <= RESP;
                    end

                    RESP: if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Directed bench for uart_boot_ctrl. Monitors capture accepted memory writes
// and accepted response bytes; each test task compares them against
// hand-computed values.
module tb_uart_boot_ctrl;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        cpu_reset;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [11:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  tx_q[$];
    int          wr_rd = 0;
    int          tx_rd = 0;

    int ready_delay = 0;
    int stall_cnt = 0;

    uart_boot_ctrl #(.ADDR_W(12), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .cpu_reset(cpu_reset), .busy(busy)
    );

    always #5 clk = ~clk;

    // memory accepts after ready_delay stalled cycles (0 = always ready)
    assign mem_ready = (ready_delay == 0) || (stall_cnt >= ready_delay);

    always @(posedge clk) begin
        if (reset) stall_cnt <= 0;
        else if (mem_we && !mem_ready) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
        if (!reset && mem_we && mem_ready) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (!reset && tx_valid && tx_ready) tx_q.push_back(tx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (mem_we === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_wait: mem_we stuck high, got %b want 0", mem_we);
        end
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_load_hdr(input logic [15:0] addr, input logic [15:0] cnt);
        send_byte(8'hA5); send_byte(8'h01);
        send_byte(addr[7:0]); send_byte(addr[15:8]);
        send_byte(cnt[7:0]); send_byte(cnt[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic get_tx(output logic [7:0] b, output bit got, input int limit);
        int n = 0;
        while (tx_q.size() <= tx_rd && n < limit) begin
            @(negedge clk);
            n++;
        end
        got = (tx_q.size() > tx_rd);
        b   = got ? tx_q[tx_rd] : 8'hxx;
        if (got) tx_rd++;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (200) @(negedge clk);
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rst_cpu_reset got %b want 1", cpu_reset); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++;
        if (tx_data !== 8'h00 || mem_addr !== 12'h000 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_data got tx %h addr %h wdata %h want 00 000 00000000", tx_data, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_load(input logic [7:0] cs, input logic [7:0] exp_rsp, input string name);
        logic [7:0] b;
        bit got;
        int base = wr_addr_q.size();
        send_load_hdr(16'h0010, 16'h0002);
        send_word(32'h00000013);
        send_word(32'h00100093);
        send_byte(cs);
        get_tx(b, got, 50);
        checks++;
        if (!got || b !== exp_rsp) begin errors++; $display("FAIL %s_rsp got %h (seen %0d) want %h", name, b, got, exp_rsp); end
        checks++;
        if (wr_addr_q.size() - base !== 2) begin
            errors++; $display("FAIL %s_nwr got %0d want 2", name, wr_addr_q.size() - base);
        end else begin
            checks++;
            if (wr_addr_q[base] !== 12'h010 || wr_data_q[base] !== 32'h00000013) begin
                errors++; $display("FAIL %s_wr0 got %h:%h want 010:00000013", name, wr_addr_q[base], wr_data_q[base]);
            end
            checks++;
            if (wr_addr_q[base+1] !== 12'h011 || wr_data_q[base+1] !== 32'h00100093) begin
                errors++; $display("FAIL %s_wr1 got %h:%h want 011:00100093", name, wr_addr_q[base+1], wr_data_q[base+1]);
            end
        end
        wr_rd = wr_addr_q.size();
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL %s_cpu_reset got %b want 1", name, cpu_reset); end
    endtask

    task automatic test_run_halt;
        logic [7:0] b;
        bit got;
        send_byte(8'hA5); send_byte(8'h02);
        get_tx(b, got, 50);
        checks++; if (!got || b !== 8'h4B) begin errors++; $display("FAIL run_rsp got %h want 4b", b); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL run_cpu_reset got %b want 0", cpu_reset); end
        send_byte(8'hA5); send_byte(8'h03);
        get_tx(b, got, 50);
        checks++; if (!got || b !== 8'h4B) begin errors++; $display("FAIL halt_rsp got %h want 4b", b); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL halt_cpu_reset got %b want 1", cpu_reset); end
    endtask

    task automatic test_unknown_cmd;
        logic [7:0] b;
        bit got;
        int base = wr_addr_q.size();
        send_byte(8'hA5); send_byte(8'h07);
        get_tx(b, got, 50);
        checks++; if (!got || b !== 8'h45) begin errors++; $display("FAIL unk_rsp got %h want 45", b); end
        checks++; if (wr_addr_q.size() !== base) begin errors++; $display("FAIL unk_nwr got %0d want 0", wr_addr_q.size() - base); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL unk_cpu_reset got %b want 1", cpu_reset); end
    endtask

    task automatic test_wrap_stall;
        logic [7:0]  b;
        bit          got;
        logic [11:0] ea;
        logic [31:0] ed;
        int base = wr_addr_q.size();
        ready_delay = 3;
        send_load_hdr(16'h0FFF, 16'h0002);
        for (int w = 0; w < 2; w++) begin
            int stalls = 0;
            int n = 0;
            ea = (w == 0) ? 12'hFFF : 12'h000;
            ed = (w == 0) ? 32'h44332211 : 32'h88776655;
            send_word(ed);
            @(negedge clk);
            while (mem_we === 1'b1 && n < 20) begin
                checks++;
                if (mem_addr !== ea || mem_wdata !== ed) begin
                    errors++; $display("FAIL stall_hold w%0d got %h:%h want %h:%h", w, mem_addr, mem_wdata, ea, ed);
                end
                if (!mem_ready) stalls++;
                @(negedge clk);
                n++;
            end
            checks++; if (stalls !== 3) begin errors++; $display("FAIL stall_len w%0d got %0d want 3", w, stalls); end
        end
        send_byte(8'h88);
        get_tx(b, got, 50);
        checks++; if (!got || b !== 8'h4B) begin errors++; $display("FAIL wrap_rsp got %h want 4b", b); end
        checks++;
        if (wr_addr_q.size() - base !== 2) begin
            errors++; $display("FAIL wrap_nwr got %0d want 2", wr_addr_q.size() - base);
        end else begin
            checks++;
            if (wr_addr_q[base] !== 12'hFFF || wr_addr_q[base+1] !== 12'h000) begin
                errors++; $display("FAIL wrap_addr got %h,%h want fff,000", wr_addr_q[base], wr_addr_q[base+1]);
            end
        end
        ready_delay = 0;
    endtask

    task automatic test_timeout;
        logic [7:0] b;
        bit got;
        bit early = 1'b0;
        int base = wr_addr_q.size();
        send_load_hdr(16'h0000, 16'h0001);
        send_byte(8'hAB);
        for (int i = 0; i < TMO - 5; i++) begin
            @(negedge clk);
            if (tx_valid) early = 1'b1;
        end
        checks++; if (early) begin errors++; $display("FAIL tmo_early got response before %0d idle cycles", TMO - 5); end
        get_tx(b, got, 20);
        checks++; if (!got || b !== 8'h45) begin errors++; $display("FAIL tmo_rsp got %h (seen %0d) want 45", b, got); end
        checks++; if (wr_addr_q.size() !== base) begin errors++; $display("FAIL tmo_nwr got %0d want 0", wr_addr_q.size() - base); end
        send_byte(8'hA5); send_byte(8'h03);
        get_tx(b, got, 50);
        checks++; if (!got || b !== 8'h4B) begin errors++; $display("FAIL tmo_next_rsp got %h want 4b", b); end
    endtask

    task automatic test_reset_in_data;
        logic [7:0] b;
        bit got;
        int base = wr_addr_q.size();
        send_load_hdr(16'h0020, 16'h0001);
        send_byte(8'h11); send_byte(8'h22);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rdata_busy_pre got %b want 1", busy); end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rdata_busy got %b want 0", busy); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL rdata_cpu_reset got %b want 1", cpu_reset); end
        checks++;
        if (mem_we !== 1'b0 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL rdata_idle got we %b txv %b want 0 0", mem_we, tx_valid);
        end
        checks++; if (wr_addr_q.size() !== base) begin errors++; $display("FAIL rdata_nwr got %0d want 0", wr_addr_q.size() - base); end
        send_byte(8'hA5); send_byte(8'h02);
        get_tx(b, got, 50);
        checks++; if (!got || b !== 8'h4B || cpu_reset !== 1'b0) begin
            errors++; $display("FAIL rdata_run got %h cpu_reset %b want 4b 0", b, cpu_reset);
        end
    endtask

    task automatic test_tx_stall;
        logic [7:0] b;
        bit got;
        int n = 0;
        tx_ready = 1'b0;
        send_byte(8'hA5); send_byte(8'h03);
        while (tx_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
                errors++; $display("FAIL txstall_hold c%0d got %b:%h want 1:4b", i, tx_valid, tx_data);
            end
        end
        // a sync byte during the response must be dropped
        send_byte(8'hA5);
        @(posedge clk); #1 tx_ready = 1'b1;
        get_tx(b, got, 20);
        checks++; if (!got || b !== 8'h4B) begin errors++; $display("FAIL txstall_rsp got %h want 4b", b); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL txstall_idle got busy %b want 0", busy); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL txstall_cpu_reset got %b want 1", cpu_reset); end
    endtask

    initial begin
        test_reset;
        test_load(8'h90, 8'h4B, "load");
        test_run_halt;
        test_load(8'h00, 8'h45, "badcs");
        test_unknown_cmd;
        test_wrap_stall;
        test_timeout;
        test_reset_in_data;
        test_tx_stall;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
